seq_div: RTL and testbench

Sequential unsigned N-bit restoring divider, the inverse counterpart of the generate-based ripple-carry adder in the arithmetic library. It retires one quotient bit per clock using an N+1-bit ripple-borrow subtractor built with a generate loop, and uses a start/done handshake. It serves datapaths that need division without a combinational array divider.

---
 rtl/seq_div_pkg.sv | 12 +
 rtl/seq_div_if.sv | 27 ++
 rtl/seq_div_gen_sub.sv | 27 ++
 rtl/seq_div.sv | 100 ++++++++++
 tb/tb_seq_div.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default width.
package seq_div_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_if.sv
// Start/done handshake bundle between a requester (master) and the divider (slave).
interface seq_div_if
  import seq_div_pkg::*;
#(
  parameter int N = DEFAULT_N
);

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_div_gen_sub.sv
// W-bit ripple-borrow subtractor (a - b) built from a chain of gate-level full-subtractor cells.
module gen_sub
  import seq_div_pkg::*;
#(
  parameter int W = DEFAULT_N + 1
) (
  output logic [W-1:0] difference,
  output logic         borrow_out,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b
);

  logic [W:0] borrow;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_cell
    logic axb;
    assign axb           = a[i] ^ b[i];
    assign difference[i] = axb ^ borrow[i];
    // Borrow out when a<b at this bit, or when the bits are equal and a borrow ripples in.
    assign borrow[i+1]   = (~a[i] & b[i]) | (~axb & borrow[i]);
  end

  assign borrow_out = borrow[W];

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_div_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [N:0]    r;
  logic [N:0]    t;
  logic [N:0]    diff;
  logic [N:0]    r_next;
  logic [N-1:0]  q;
  logic [N-1:0]  q_next;
  logic [N-1:0]  d;
  logic          borrow;
  logic          accept;
  logic          last;
  logic [N-1:0]  quotient_r;
  logic [N-1:0]  remainder_r;
  logic          dbz_r;

  assign t = {r[N-1:0], q[N-1]};

  gen_sub #(.W(N + 1)) u_sub (
    .difference (diff),
    .borrow_out (borrow),
    .a          (t),
    .b          ({1'b0, d})
  );

  // A borrow means the trial subtraction failed, so the shifted remainder is restored.
  assign r_next = borrow ? t : diff;
  assign q_next = {q[N-2:0], ~borrow};
  assign accept = ((state == IDLE) || (state == DONE)) && bus.start;
  assign last   = (cnt == CW'(1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start) state_next = (bus.divisor == '0) ? DONE : RUN;
        else           state_next = IDLE;
      end
      RUN:     if (last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (bus.divisor != '0) begin
          q     <= bus.dividend;
          d     <= bus.divisor;
          r     <= '0;
          cnt   <= CW'(N);
          dbz_r <= 1'b0;
        end else begin
          quotient_r  <= '1;
          remainder_r <= bus.dividend;
          dbz_r       <= 1'b1;
        end
      end else if (state == RUN) begin
        r   <= r_next;
        q   <= q_next;
        cnt <= cnt - CW'(1);
        if (last) begin
          quotient_r  <= q_next;
          remainder_r <= r_next[N-1:0];
        end
      end
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_div.sv
// Directed and exhaustive checks of seq_div (N=4) against hand-computed results.
module tb_seq_div;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   lat;
  int   busyCycles;
  logic sawDone;

  seq_div_if #(.N(N)) bus ();

  seq_div #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Present operands with a one-cycle start pulse; returns in cycle 1 after the accept edge.
  task automatic applyStimulus(input int a, input int b);
    bus.dividend = N'(a);
    bus.divisor  = N'(b);
    bus.start    = 1'b1;
    nextCycle();
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input int startLat, output int latOut, output int busyOut);
    latOut  = startLat;
    busyOut = 0;
    while (!bus.done && latOut < 20) begin
      if (bus.busy) busyOut++;
      nextCycle();
      latOut++;
    end
  endtask

  task automatic checkResult(input string tag, input int expQ, input int expR, input int expZ);
    checkOutput({tag, ".done"}, 32'(bus.done), 32'd1);
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, ".q"}, 32'(bus.quotient), 32'(expQ));
    checkOutput({tag, ".r"}, 32'(bus.remainder), 32'(expR));
    checkOutput({tag, ".dbz"}, 32'(bus.div_by_zero), 32'(expZ));
  endtask

  task automatic runDivision(input string tag, input int a, input int b,
                             input int expQ, input int expR, input int expZ,
                             input int expLat, input int expBusy);
    applyStimulus(a, b);
    waitDone(1, lat, busyCycles);
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ".busycycles"}, 32'(busyCycles), 32'(expBusy));
    checkResult(tag, expQ, expR, expZ);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, ".done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, ".q"}, 32'(bus.quotient), 32'd0);
    checkOutput({tag, ".r"}, 32'(bus.remainder), 32'd0);
    checkOutput({tag, ".dbz"}, 32'(bus.div_by_zero), 32'd0);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    nextCycle();
    nextCycle();
    checkCleared("reset");
    rst_n = 1'b1;
    nextCycle();

    runDivision("13/4", 13, 4, 3, 1, 0, 5, 4);
    runDivision("15/1", 15, 1, 15, 0, 0, 5, 4);
    runDivision("3/7", 3, 7, 0, 3, 0, 5, 4);
    runDivision("0/5", 0, 5, 0, 0, 0, 5, 4);
    runDivision("9/0", 9, 0, 15, 9, 1, 1, 0);
    runDivision("8/2", 8, 2, 4, 0, 0, 5, 4);

    // Start raised mid-run must be ignored, then stay high into DONE for a back-to-back divide.
    applyStimulus(13, 4);
    nextCycle();
    bus.dividend = 4'd6;
    bus.divisor  = 4'd3;
    bus.start    = 1'b1;
    waitDone(2, lat, busyCycles);
    checkOutput("ignore.latency", 32'(lat), 32'd5);
    checkResult("ignore", 3, 1, 0);
    nextCycle();
    bus.start = 1'b0;
    waitDone(1, lat, busyCycles);
    checkOutput("b2b.latency", 32'(lat), 32'd5);
    checkOutput("b2b.busycycles", 32'(busyCycles), 32'd4);
    checkResult("b2b", 2, 0, 0);
    nextCycle();

    applyStimulus(14, 3);
    nextCycle();
    rst_n = 1'b0;
    nextCycle();
    checkCleared("midreset");
    rst_n   = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      sawDone = sawDone | bus.done;
    end
    checkOutput("midreset.nodone", 32'(sawDone), 32'd0);
    runDivision("14/3", 14, 3, 4, 2, 0, 5, 4);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(a, b);
        waitDone(1, lat, busyCycles);
        checkOutput($sformatf("sweep%0d/%0d.latency", a, b), 32'(lat), (b == 0) ? 32'd1 : 32'd5);
        checkOutput($sformatf("sweep%0d/%0d.q", a, b), 32'(bus.quotient), (b == 0) ? 32'd15 : 32'(a / b));
        checkOutput($sformatf("sweep%0d/%0d.r", a, b), 32'(bus.remainder), (b == 0) ? 32'(a) : 32'(a % b));
        checkOutput($sformatf("sweep%0d/%0d.dbz", a, b), 32'(bus.div_by_zero), (b == 0) ? 32'd1 : 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
